// File: rtl/sdram_wb_bridge_if.sv
// Wishbone-classic bus between the kernel master and the SDRAM bridge.
// Signal names keep the slave-side _i/_o suffixes of the original flat ports.
interface sdram_wb_bridge_if;
  logic [20:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/sdram_wb_bridge.sv
// Wishbone-classic slave to SDRAM-controller req/ack bridge with init gate,
// request watchdog and abort handling.
module sdram_wb_bridge #(
  parameter int unsigned ACK_DELAY = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sdram_wb_bridge_if.slave        wb,
  input  logic                    sdram_init_done,
  output logic                    sdram_wr_req,
  output logic                    sdram_rd_req,
  input  logic                    sdram_wr_ack,
  input  logic                    sdram_rd_ack,
  output logic [21:0]             sdram_addr,
  output logic [15:0]             sdram_wdata,
  input  logic [15:0]             sdram_rdata,
  output logic [1:0]              sdram_byteenable,
  output logic [1:0]              sdram_dqm,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {IDLE, REQ, DLY, ACK, DONE} state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  localparam logic [2:0] DLY_LAST = 3'(ACK_DELAY - 1);

  state_t      state_q;
  logic [7:0]  wd_q;
  logic [2:0]  dly_q;
  logic        we_q;
  logic        ack_q;
  logic        abort_q;
  logic        wr_ack_q, rd_ack_q;
  logic        wr_req_q, rd_req_q;
  logic [20:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [1:0]  be_q;
  logic [1:0]  dqm_q;
  logic        terr_q;

  logic ack_match;
  logic skip_ack;

  // Controller acks go through one register stage, so a request drops on the
  // edge after the ack is sampled.
  assign ack_match = we_q ? wr_ack_q : rd_ack_q;
  // A master that let go of stb at any point before ACK gets no ack pulse.
  assign skip_ack  = abort_q | ~wb.wb_stb_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wd_q     <= '0;
      dly_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      abort_q  <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      dqm_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      wr_ack_q <= sdram_wr_ack;
      rd_ack_q <= sdram_rd_ack;
      case (state_q)
        IDLE: begin
          if (sdram_init_done && wb.wb_stb_i) begin
            addr_q  <= wb.wb_adr_i;
            wdata_q <= wb.wb_dat_i;
            be_q    <= wb.wb_sel_i;
            we_q    <= wb.wb_we_i;
            dqm_q   <= wb.wb_we_i ? ~wb.wb_sel_i : 2'b00;
            wd_q    <= '0;
            abort_q <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!wb.wb_stb_i) abort_q <= 1'b1;
          if (ack_match) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            dly_q    <= '0;
            state_q  <= DLY;
          end else if (wd_q == WD_LIMIT) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            terr_q   <= 1'b1;
            rdata_q  <= '1;
            if (skip_ack) begin
              state_q <= DONE;
            end else begin
              ack_q   <= 1'b1;
              state_q <= ACK;
            end
          end else begin
            wd_q     <= wd_q + 8'd1;
            wr_req_q <= we_q;
            rd_req_q <= ~we_q;
          end
        end
        DLY: begin
          if (!wb.wb_stb_i) abort_q <= 1'b1;
          if (!we_q) rdata_q <= sdram_rdata;
          if (dly_q == DLY_LAST) begin
            if (skip_ack) begin
              state_q <= DONE;
            end else begin
              ack_q   <= 1'b1;
              state_q <= ACK;
            end
          end else begin
            dly_q <= dly_q + 3'd1;
          end
        end
        ACK: begin
          if (!wb.wb_stb_i) begin
            ack_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o      = ack_q & wb.wb_stb_i;
  assign wb.wb_dat_o      = rdata_q;
  assign sdram_wr_req     = wr_req_q;
  assign sdram_rd_req     = rd_req_q;
  assign sdram_addr       = {1'b0, addr_q};
  assign sdram_wdata      = wdata_q;
  assign sdram_byteenable = be_q;
  assign sdram_dqm        = dqm_q;
  assign timeout_err      = terr_q;

endmodule
